dmem_req_arbiter: RTL and testbench

//  Shares the single data-cache request/response port between two requesters: port 0 (integer LSU) and port 1 (FP LSU / page walker).

---
 rtl/dmem_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_req_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_arbiter.sv
// Two-requester arbiter in front of the single DCACHE request/response port.
// Round-robin issue, one transaction in flight, NACK replay, tag-routed responses.
module dmem_req_arbiter #(
  parameter int ADDR_W      = 40,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  input  logic [4:0]        REQ0_CMD,
  input  logic [3:0]        REQ0_TYPE,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DATA,
  input  logic [4:0]        REQ0_DST,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [4:0]        REQ1_CMD,
  input  logic [3:0]        REQ1_TYPE,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DATA,
  input  logic [4:0]        REQ1_DST,
  output logic              REQ1_READY,
  output logic              RESP0_VALID,
  output logic [DATA_W-1:0] RESP0_DATA,
  output logic              RESP1_VALID,
  output logic [DATA_W-1:0] RESP1_DATA,
  input  logic              KILL,
  output logic              DMEM_REQ_VALID,
  input  logic              DMEM_REQ_READY,
  output logic [4:0]        DMEM_REQ_CMD,
  output logic [3:0]        DMEM_REQ_TYPE,
  output logic [ADDR_W-1:0] DMEM_REQ_ADDR,
  output logic [DATA_W-1:0] DMEM_REQ_DATA,
  output logic [7:0]        DMEM_REQ_TAG,
  output logic              DMEM_REQ_KILL,
  input  logic              DMEM_RESP_VALID,
  input  logic [7:0]        DMEM_RESP_TAG,
  input  logic [DATA_W-1:0] DMEM_RESP_DATA,
  input  logic              DMEM_RESP_NACK,
  output logic              BUSY,
  output logic              TIMEOUT_ERR
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  typedef struct packed {
    logic [4:0]        cmd;
    logic [3:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [4:0]        dst;
    logic              sel;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT_RESP, REPLAY} state_t;

  state_t     state, state_nxt;
  logic       last;
  logic [7:0] cnt, cnt_nxt;
  req_t       held, mux_req, cur;
  logic       sel, any_vld, tag_match, issue;
  logic       r0v, r1v;

  assign any_vld   = REQ0_VALID | REQ1_VALID;
  // Tie goes to the port that did not win last; a lone requester always wins.
  assign sel       = (REQ0_VALID & REQ1_VALID) ? ~last : REQ1_VALID;
  assign tag_match = DMEM_RESP_VALID && (DMEM_RESP_TAG == {2'b00, held.dst, held.sel});

  always_comb begin
    mux_req = '0;
    if (sel) begin
      mux_req.cmd  = REQ1_CMD;
      mux_req.typ  = REQ1_TYPE;
      mux_req.addr = REQ1_ADDR;
      mux_req.data = REQ1_DATA;
      mux_req.dst  = REQ1_DST;
      mux_req.sel  = 1'b1;
    end else begin
      mux_req.cmd  = REQ0_CMD;
      mux_req.typ  = REQ0_TYPE;
      mux_req.addr = REQ0_ADDR;
      mux_req.data = REQ0_DATA;
      mux_req.dst  = REQ0_DST;
      mux_req.sel  = 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = '0;
    cur            = held;
    DMEM_REQ_VALID = 1'b0;
    DMEM_REQ_KILL  = 1'b0;
    REQ0_READY     = 1'b0;
    REQ1_READY     = 1'b0;
    r0v            = 1'b0;
    r1v            = 1'b0;
    TIMEOUT_ERR    = 1'b0;
    issue          = 1'b0;
    case (state)
      IDLE: begin
        DMEM_REQ_VALID = any_vld & ~KILL;
        cur            = DMEM_REQ_VALID ? mux_req : '0;
        if (DMEM_REQ_VALID && DMEM_REQ_READY) begin
          issue      = 1'b1;
          REQ0_READY = ~sel;
          REQ1_READY = sel;
          state_nxt  = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        cnt_nxt = cnt + 8'd1;
        if (KILL) begin
          DMEM_REQ_KILL = 1'b1;
          state_nxt     = IDLE;
        end else if (tag_match) begin
          r0v       = ~held.sel;
          r1v       = held.sel;
          state_nxt = IDLE;
        end else if (DMEM_RESP_NACK) begin
          state_nxt = REPLAY;
        end else if (cnt == TMO) begin
          TIMEOUT_ERR   = 1'b1;
          DMEM_REQ_KILL = 1'b1;
          state_nxt     = IDLE;
        end
      end
      REPLAY: begin
        // Reissue from the held copy; the requester already saw its READY.
        if (KILL) begin
          DMEM_REQ_KILL = 1'b1;
          state_nxt     = IDLE;
        end else begin
          DMEM_REQ_VALID = 1'b1;
          if (DMEM_REQ_READY) state_nxt = WAIT_RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      held  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (issue) begin
        held <= mux_req;
        last <= sel;
      end
    end
  end

  assign DMEM_REQ_CMD  = cur.cmd;
  assign DMEM_REQ_TYPE = cur.typ;
  assign DMEM_REQ_ADDR = cur.addr;
  assign DMEM_REQ_DATA = cur.data;
  assign DMEM_REQ_TAG  = {2'b00, cur.dst, cur.sel};
  assign RESP0_VALID   = r0v;
  assign RESP1_VALID   = r1v;
  assign RESP0_DATA    = r0v ? DMEM_RESP_DATA : '0;
  assign RESP1_DATA    = r1v ? DMEM_RESP_DATA : '0;
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// Directed bench for dmem_req_arbiter: one task per scenario, inline checks.
module tb_dmem_req_arbiter;
  localparam int AW = 40;
  localparam int DW = 64;

  logic          CLK, RST;
  logic          REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
  logic [4:0]    REQ0_CMD, REQ1_CMD, REQ0_DST, REQ1_DST;
  logic [3:0]    REQ0_TYPE, REQ1_TYPE;
  logic [AW-1:0] REQ0_ADDR, REQ1_ADDR;
  logic [DW-1:0] REQ0_DATA, REQ1_DATA;
  logic          RESP0_VALID, RESP1_VALID;
  logic [DW-1:0] RESP0_DATA, RESP1_DATA;
  logic          KILL;
  logic          DMEM_REQ_VALID, DMEM_REQ_READY, DMEM_REQ_KILL;
  logic [4:0]    DMEM_REQ_CMD;
  logic [3:0]    DMEM_REQ_TYPE;
  logic [AW-1:0] DMEM_REQ_ADDR;
  logic [DW-1:0] DMEM_REQ_DATA;
  logic [7:0]    DMEM_REQ_TAG, DMEM_RESP_TAG;
  logic          DMEM_RESP_VALID, DMEM_RESP_NACK;
  logic [DW-1:0] DMEM_RESP_DATA;
  logic          BUSY, TIMEOUT_ERR;

  int tests = 0;
  int fails = 0;

  dmem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(255)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_CMD(REQ0_CMD), .REQ0_TYPE(REQ0_TYPE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_DATA(REQ0_DATA), .REQ0_DST(REQ0_DST), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_CMD(REQ1_CMD), .REQ1_TYPE(REQ1_TYPE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_DATA(REQ1_DATA), .REQ1_DST(REQ1_DST), .REQ1_READY(REQ1_READY),
    .RESP0_VALID(RESP0_VALID), .RESP0_DATA(RESP0_DATA),
    .RESP1_VALID(RESP1_VALID), .RESP1_DATA(RESP1_DATA),
    .KILL(KILL),
    .DMEM_REQ_VALID(DMEM_REQ_VALID), .DMEM_REQ_READY(DMEM_REQ_READY),
    .DMEM_REQ_CMD(DMEM_REQ_CMD), .DMEM_REQ_TYPE(DMEM_REQ_TYPE), .DMEM_REQ_ADDR(DMEM_REQ_ADDR),
    .DMEM_REQ_DATA(DMEM_REQ_DATA), .DMEM_REQ_TAG(DMEM_REQ_TAG), .DMEM_REQ_KILL(DMEM_REQ_KILL),
    .DMEM_RESP_VALID(DMEM_RESP_VALID), .DMEM_RESP_TAG(DMEM_RESP_TAG),
    .DMEM_RESP_DATA(DMEM_RESP_DATA), .DMEM_RESP_NACK(DMEM_RESP_NACK),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    REQ0_VALID = 0; REQ0_CMD = 0; REQ0_TYPE = 0; REQ0_ADDR = 0; REQ0_DATA = 0; REQ0_DST = 0;
    REQ1_VALID = 0; REQ1_CMD = 0; REQ1_TYPE = 0; REQ1_ADDR = 0; REQ1_DATA = 0; REQ1_DST = 0;
    KILL = 0; DMEM_REQ_READY = 0; DMEM_RESP_VALID = 0; DMEM_RESP_TAG = 0;
    DMEM_RESP_DATA = 0; DMEM_RESP_NACK = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    clear_inputs();
    #2;
    tests++; if (DMEM_REQ_VALID !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b exp 0", DMEM_REQ_VALID); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    tests++; if ({REQ0_READY, REQ1_READY, RESP0_VALID, RESP1_VALID, DMEM_REQ_KILL, TIMEOUT_ERR} !== 6'b0)
      begin fails++; $display("FAIL reset_ctl got %b exp 000000", {REQ0_READY, REQ1_READY, RESP0_VALID, RESP1_VALID, DMEM_REQ_KILL, TIMEOUT_ERR}); end
    tests++; if ({DMEM_REQ_TAG, DMEM_REQ_ADDR, DMEM_REQ_DATA} !== '0)
      begin fails++; $display("FAIL reset_fields tag %h addr %h data %h exp 0", DMEM_REQ_TAG, DMEM_REQ_ADDR, DMEM_REQ_DATA); end
    step();
    RST = 0;
  endtask

  task automatic test_basic_load();
    REQ0_VALID = 1; REQ0_CMD = 5'd0; REQ0_ADDR = 40'h80001000; REQ0_DST = 5'd5; DMEM_REQ_READY = 1;
    #1;
    tests++; if (DMEM_REQ_TAG !== 8'h0A) begin fails++; $display("FAIL basic_tag got %h exp 0a", DMEM_REQ_TAG); end
    tests++; if (DMEM_REQ_ADDR !== 40'h80001000) begin fails++; $display("FAIL basic_addr got %h exp 80001000", DMEM_REQ_ADDR); end
    tests++; if ({DMEM_REQ_VALID, REQ0_READY, REQ1_READY} !== 3'b110)
      begin fails++; $display("FAIL basic_hs got %b exp 110", {DMEM_REQ_VALID, REQ0_READY, REQ1_READY}); end
    step();
    REQ0_VALID = 0; DMEM_REQ_READY = 0;
    #1;
    tests++; if ({BUSY, DMEM_REQ_VALID} !== 2'b10) begin fails++; $display("FAIL basic_wait got %b exp 10", {BUSY, DMEM_REQ_VALID}); end
    step();
    step();
    DMEM_RESP_VALID = 1; DMEM_RESP_TAG = 8'h0A; DMEM_RESP_DATA = 64'h1234;
    #1;
    tests++; if ({RESP0_VALID, RESP1_VALID} !== 2'b10) begin fails++; $display("FAIL basic_resp_vld got %b exp 10", {RESP0_VALID, RESP1_VALID}); end
    tests++; if (RESP0_DATA !== 64'h1234) begin fails++; $display("FAIL basic_resp_data got %h exp 1234", RESP0_DATA); end
    step();
    clear_inputs();
    #1;
    tests++; if ({BUSY, RESP0_VALID} !== 2'b00) begin fails++; $display("FAIL basic_done got %b exp 00", {BUSY, RESP0_VALID}); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_tag;
    RST = 1; #1; RST = 0;
    REQ0_VALID = 1; REQ0_DST = 5'd1; REQ0_ADDR = 40'h100;
    REQ1_VALID = 1; REQ1_DST = 5'd2; REQ1_ADDR = 40'h200;
    DMEM_REQ_READY = 1;
    for (int i = 0; i < 4; i++) begin
      exp_tag = (i % 2 == 0) ? 8'h02 : 8'h05;
      #1;
      tests++; if ({REQ0_READY, REQ1_READY} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        begin fails++; $display("FAIL rr_grant%0d got %b", i, {REQ0_READY, REQ1_READY}); end
      tests++; if (DMEM_REQ_TAG !== exp_tag) begin fails++; $display("FAIL rr_tag%0d got %h exp %h", i, DMEM_REQ_TAG, exp_tag); end
      step();
      DMEM_RESP_VALID = 1; DMEM_RESP_TAG = exp_tag; DMEM_RESP_DATA = 64'(i + 16);
      #1;
      tests++; if ({RESP0_VALID, RESP1_VALID} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        begin fails++; $display("FAIL rr_resp%0d got %b", i, {RESP0_VALID, RESP1_VALID}); end
      step();
      DMEM_RESP_VALID = 0;
    end
    clear_inputs();
  endtask

  task automatic test_nack_replay();
    REQ0_VALID = 1; REQ0_CMD = 5'd1; REQ0_ADDR = 40'h1234567890; REQ0_DATA = 64'hDEADBEEF00000001;
    REQ0_DST = 5'd7; DMEM_REQ_READY = 1;
    step();
    DMEM_REQ_READY = 0; DMEM_RESP_NACK = 1;
    step();
    DMEM_RESP_NACK = 0;
    #1;
    tests++; if ({DMEM_REQ_VALID, BUSY, REQ0_READY} !== 3'b110)
      begin fails++; $display("FAIL nack_replay_ctl got %b exp 110", {DMEM_REQ_VALID, BUSY, REQ0_READY}); end
    tests++; if ({DMEM_REQ_TAG, DMEM_REQ_CMD, DMEM_REQ_ADDR, DMEM_REQ_DATA} !== {8'h0E, 5'd1, 40'h1234567890, 64'hDEADBEEF00000001})
      begin fails++; $display("FAIL nack_fields tag %h cmd %h addr %h data %h", DMEM_REQ_TAG, DMEM_REQ_CMD, DMEM_REQ_ADDR, DMEM_REQ_DATA); end
    DMEM_REQ_READY = 1;
    #1;
    tests++; if ({DMEM_REQ_VALID, REQ0_READY} !== 2'b10)
      begin fails++; $display("FAIL nack_no_reready got %b exp 10", {DMEM_REQ_VALID, REQ0_READY}); end
    step();
    REQ0_VALID = 0; DMEM_REQ_READY = 0;
    DMEM_RESP_VALID = 1; DMEM_RESP_TAG = 8'h0E; DMEM_RESP_DATA = 64'hCAFE;
    #1;
    tests++; if ({RESP0_VALID, RESP0_DATA} !== {1'b1, 64'hCAFE})
      begin fails++; $display("FAIL nack_resp got %b/%h exp 1/cafe", RESP0_VALID, RESP0_DATA); end
    step();
    clear_inputs();
    #1;
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL nack_done busy got %b exp 0", BUSY); end
  endtask

  task automatic test_kill();
    REQ1_VALID = 1; REQ1_DST = 5'd3; REQ1_ADDR = 40'h40; DMEM_REQ_READY = 1;
    #1;
    tests++; if ({REQ1_READY, DMEM_REQ_TAG} !== {1'b1, 8'h07})
      begin fails++; $display("FAIL kill_issue got %b/%h exp 1/07", REQ1_READY, DMEM_REQ_TAG); end
    step();
    REQ1_VALID = 0; DMEM_REQ_READY = 0;
    DMEM_RESP_VALID = 1; DMEM_RESP_TAG = 8'h09;
    #1;
    tests++; if ({RESP0_VALID, RESP1_VALID} !== 2'b00) begin fails++; $display("FAIL kill_wrongtag got %b exp 00", {RESP0_VALID, RESP1_VALID}); end
    step();
    DMEM_RESP_TAG = 8'h07; KILL = 1;
    #1;
    tests++; if ({BUSY, RESP1_VALID, DMEM_REQ_KILL} !== 3'b101)
      begin fails++; $display("FAIL kill_suppress got %b exp 101", {BUSY, RESP1_VALID, DMEM_REQ_KILL}); end
    step();
    DMEM_RESP_VALID = 0; KILL = 0;
    #1;
    tests++; if ({BUSY, DMEM_REQ_KILL} !== 2'b00) begin fails++; $display("FAIL kill_idle got %b exp 00", {BUSY, DMEM_REQ_KILL}); end
    REQ0_VALID = 1; DMEM_REQ_READY = 1; KILL = 1;
    #1;
    tests++; if ({DMEM_REQ_VALID, REQ0_READY} !== 2'b00) begin fails++; $display("FAIL kill_blocks_issue got %b exp 00", {DMEM_REQ_VALID, REQ0_READY}); end
    step();
    clear_inputs();
    #1;
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL kill_blocked_busy got %b exp 0", BUSY); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    REQ0_VALID = 1; REQ0_DST = 5'd0; DMEM_REQ_READY = 1;
    step();
    clear_inputs();
    // Counter starts at 0 on the first WAIT_RESP cycle; abandon when it reaches 255.
    for (int i = 0; i < 255; i++) begin
      #1;
      if (TIMEOUT_ERR !== 1'b0 || BUSY !== 1'b1) early++;
      step();
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL tmo_early got %0d bad cycles exp 0", early); end
    REQ1_VALID = 1; REQ1_DST = 5'd4; DMEM_REQ_READY = 1;
    #1;
    tests++; if ({TIMEOUT_ERR, DMEM_REQ_KILL, RESP0_VALID, REQ1_READY} !== 4'b1100)
      begin fails++; $display("FAIL tmo_pulse got %b exp 1100", {TIMEOUT_ERR, DMEM_REQ_KILL, RESP0_VALID, REQ1_READY}); end
    step();
    #1;
    tests++; if ({BUSY, TIMEOUT_ERR, DMEM_REQ_VALID, REQ1_READY, DMEM_REQ_TAG} !== {4'b0011, 8'h09})
      begin fails++; $display("FAIL tmo_next_req got %b/%h exp 0011/09", {BUSY, TIMEOUT_ERR, DMEM_REQ_VALID, REQ1_READY}, DMEM_REQ_TAG); end
    step();
    REQ1_VALID = 0; DMEM_REQ_READY = 0; DMEM_RESP_VALID = 1; DMEM_RESP_TAG = 8'h09;
    #1;
    tests++; if (RESP1_VALID !== 1'b1) begin fails++; $display("FAIL tmo_after_resp got %b exp 1", RESP1_VALID); end
    step();
    clear_inputs();
  endtask

  task automatic test_rst_in_replay();
    REQ0_VALID = 1; REQ0_DST = 5'd2; REQ0_ADDR = 40'hABC0; DMEM_REQ_READY = 1;
    step();
    REQ0_VALID = 0; DMEM_REQ_READY = 0; DMEM_RESP_NACK = 1;
    step();
    DMEM_RESP_NACK = 0;
    #1;
    tests++; if ({DMEM_REQ_VALID, DMEM_REQ_TAG} !== {1'b1, 8'h04})
      begin fails++; $display("FAIL rst_replay_pre got %b/%h exp 1/04", DMEM_REQ_VALID, DMEM_REQ_TAG); end
    RST = 1;
    #1;
    tests++; if ({DMEM_REQ_VALID, BUSY, DMEM_REQ_KILL, DMEM_REQ_TAG, DMEM_REQ_ADDR} !== '0)
      begin fails++; $display("FAIL rst_async got vld %b busy %b tag %h addr %h exp 0", DMEM_REQ_VALID, BUSY, DMEM_REQ_TAG, DMEM_REQ_ADDR); end
    step();
    RST = 0;
    step();
    DMEM_RESP_VALID = 1; DMEM_RESP_TAG = 8'h04; DMEM_RESP_DATA = 64'h55;
    #1;
    tests++; if ({RESP0_VALID, RESP1_VALID, BUSY} !== 3'b000)
      begin fails++; $display("FAIL rst_stale_resp got %b exp 000", {RESP0_VALID, RESP1_VALID, BUSY}); end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_round_robin();
    test_nack_replay();
    test_kill();
    test_timeout();
    test_rst_in_replay();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
